// File: rtl/veerwolf_board_io_pkg.sv
// Shared types and sizing helper for the veerwolf board I/O conditioner.
package veerwolf_board_io_pkg;

  typedef enum logic {UMUX_ACTIVE = 1'b0, UMUX_WAIT = 1'b1} umux_state_t;

  // Counter/select width: max(1, clog2(n)).
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

endpackage

// File: rtl/veerwolf_debounce.sv
// One switch bit: 2-FF synchroniser, stability counter, debounced level and edge pulses.
module veerwolf_debounce
  import veerwolf_board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_sw,
  output logic o_db,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'sd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  logic          meta_r;
  logic          sync_r;
  logic [CW-1:0] cnt_r;
  logic          accept_s;

  assign accept_s = (sync_r != o_db) && (cnt_r == CNT_LAST);

  // two-flop synchroniser for the raw pin
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= i_sw;
      sync_r <= meta_r;
    end
  end

  // stability counter, accepted level and single-cycle edge pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r  <= '0;
      o_db   <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      o_rise <= accept_s & sync_r;
      o_fall <= accept_s & ~sync_r;
      if (accept_s) begin
        o_db  <= sync_r;
        cnt_r <= '0;
      end else if (sync_r != o_db) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= '0;
      end
    end
  end

endmodule

// File: rtl/veerwolf_board_io.sv
// Board I/O conditioner: debounced switches, registered LEDs and a glitch-free UART TX mux.
// Define VEERWOLF_LED_PWM_EN to enable PWM dimming of the LED outputs.
module veerwolf_board_io
  import veerwolf_board_io_pkg::*;
#(
  parameter  int NUM_SW          = 8,
  parameter  int NUM_LED         = 8,
  parameter  int NUM_UART        = 2,
  parameter  int DEBOUNCE_CYCLES = 50000,
  parameter  int IDLE_CYCLES     = 5208,
  parameter  int PWM_BITS        = 4,
  localparam int SELW            = cnt_w(NUM_UART)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_SW-1:0]   i_sw,
  output logic [NUM_SW-1:0]   o_sw_db,
  output logic [NUM_SW-1:0]   o_sw_rise,
  output logic [NUM_SW-1:0]   o_sw_fall,
  input  logic [NUM_LED-1:0]  i_led,
  input  logic [PWM_BITS-1:0] i_led_dim,
  output logic [NUM_LED-1:0]  o_led,
  input  logic [NUM_UART-1:0] i_uart_tx,
  input  logic [SELW-1:0]     i_uart_sel,
  output logic                o_uart_tx,
  output logic [SELW-1:0]     o_uart_cur
);

  localparam int IW = cnt_w(IDLE_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 32'sd1);
  localparam logic [IW-1:0] IDLE_ONE  = IW'(32'd1);
  localparam logic [SELW:0] SEL_LIMIT = (SELW + 1)'(NUM_UART);

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    veerwolf_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rstn  (rstn),
      .i_sw  (i_sw[g]),
      .o_db  (o_sw_db[g]),
      .o_rise(o_sw_rise[g]),
      .o_fall(o_sw_fall[g])
    );
  end

  logic [NUM_LED-1:0] led_r;

`ifdef VEERWOLF_LED_PWM_EN
  localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(32'd1);

  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [PWM_BITS-1:0] dim_r;
  logic                led_gate_s;

  // all-ones brightness bypasses the comparator so the LED is never blanked
  assign led_gate_s = (pwm_cnt_r < dim_r) | (&dim_r);

  // free-running PWM phase and registered brightness
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pwm_cnt_r <= '0;
      dim_r     <= '0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
      dim_r     <= i_led_dim;
    end
  end

  // two LED stages, the second one gated by the PWM phase
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led_r <= '0;
      o_led <= '0;
    end else begin
      led_r <= i_led;
      o_led <= led_r & {NUM_LED{led_gate_s}};
    end
  end
`else
  logic unused_dim_s;
  assign unused_dim_s = ^i_led_dim;

  // two plain LED register stages
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led_r <= '0;
      o_led <= '0;
    end else begin
      led_r <= i_led;
      o_led <= led_r;
    end
  end
`endif

  umux_state_t     state_r;
  umux_state_t     state_n_s;
  logic [SELW-1:0] sel_meta_r;
  logic [SELW-1:0] sel_sync_r;
  logic [SELW-1:0] sel_s;
  logic [SELW-1:0] cur_n_s;
  logic [SELW-1:0] tgt_r;
  logic [SELW-1:0] tgt_n_s;
  logic [IW-1:0]   idle_r;
  logic [IW-1:0]   idle_n_s;
  logic            both_idle_s;

  // out-of-range requests alias to the current source and are thus ignored
  assign sel_s       = ({1'b0, sel_sync_r} >= SEL_LIMIT) ? o_uart_cur : sel_sync_r;
  assign both_idle_s = i_uart_tx[o_uart_cur] & i_uart_tx[tgt_r];

  // select synchroniser, mux state and registered TX pin
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_meta_r <= '0;
      sel_sync_r <= '0;
      state_r    <= UMUX_ACTIVE;
      o_uart_cur <= '0;
      tgt_r      <= '0;
      idle_r     <= '0;
      o_uart_tx  <= 1'b1;
    end else begin
      sel_meta_r <= i_uart_sel;
      sel_sync_r <= sel_meta_r;
      state_r    <= state_n_s;
      o_uart_cur <= cur_n_s;
      tgt_r      <= tgt_n_s;
      idle_r     <= idle_n_s;
      o_uart_tx  <= i_uart_tx[o_uart_cur];
    end
  end

  // switch only after both old and new source have idled high long enough
  always_comb begin
    state_n_s = state_r;
    cur_n_s   = o_uart_cur;
    tgt_n_s   = tgt_r;
    idle_n_s  = idle_r;
    case (state_r)
      UMUX_ACTIVE: begin
        if (sel_s != o_uart_cur) begin
          tgt_n_s   = sel_s;
          idle_n_s  = '0;
          state_n_s = UMUX_WAIT;
        end else begin
          state_n_s = UMUX_ACTIVE;
        end
      end
      UMUX_WAIT: begin
        if (sel_s == o_uart_cur) begin
          state_n_s = UMUX_ACTIVE;
        end else if (sel_s != tgt_r) begin
          tgt_n_s  = sel_s;
          idle_n_s = '0;
        end else if (both_idle_s) begin
          if (idle_r == IDLE_LAST) begin
            cur_n_s   = tgt_r;
            idle_n_s  = '0;
            state_n_s = UMUX_ACTIVE;
          end else begin
            idle_n_s = idle_r + IDLE_ONE;
          end
        end else begin
          idle_n_s = '0;
        end
      end
      default: begin
        state_n_s = UMUX_ACTIVE;
      end
    endcase
  end

endmodule

// File: tb/tb_veerwolf_board_io.sv
// Self-checking bench for veerwolf_board_io: directed scenarios plus a random phase
// compared every cycle against a window-based reference model.
module tb_veerwolf_board_io;

  localparam int DB = 8;
  localparam int HL = 20;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] i_sw;
  logic [7:0] o_sw_db;
  logic [7:0] o_sw_rise;
  logic [7:0] o_sw_fall;
  logic [7:0] i_led;
  logic [3:0] i_led_dim;
  logic [7:0] o_led;
  logic [2:0] i_uart_tx;
  logic [1:0] i_uart_sel;
  logic       o_uart_tx;
  logic [1:0] o_uart_cur;

  int n_tests = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int last_low0 = 0;
  int lat;
  int sw_edge;
  int on_cnt;
  int off_cnt;
  logic chk_led = 1'b1;
  logic [9:0] frame;

  logic [7:0] sw_q[$];
  logic [7:0] led_q[$];
  logic [1:0] sel_q[$];
  logic [2:0] tx_q[$];
  logic [7:0] m_db;
  logic [7:0] m_rise;
  logic [7:0] m_fall;
  logic [1:0] m_cur;
  logic       m_tx;

  veerwolf_board_io #(
    .NUM_SW(8), .NUM_LED(8), .NUM_UART(3),
    .DEBOUNCE_CYCLES(8), .IDLE_CYCLES(16), .PWM_BITS(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .i_sw(i_sw), .o_sw_db(o_sw_db), .o_sw_rise(o_sw_rise), .o_sw_fall(o_sw_fall),
    .i_led(i_led), .i_led_dim(i_led_dim), .o_led(o_led),
    .i_uart_tx(i_uart_tx), .i_uart_sel(i_uart_sel),
    .o_uart_tx(o_uart_tx), .o_uart_cur(o_uart_cur)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sw_q.delete();
    led_q.delete();
    sel_q.delete();
    tx_q.delete();
    for (int i = 0; i < HL; i++) begin
      sw_q.push_back(8'h00);
      led_q.push_back(8'h00);
      sel_q.push_back(2'd0);
      tx_q.push_back(3'd0);
    end
    m_db   = 8'h00;
    m_rise = 8'h00;
    m_fall = 8'h00;
    m_cur  = 2'd0;
    m_tx   = 1'b1;
  endtask

  // One clock: record the inputs the DUT samples, advance the model, compare all outputs.
  task automatic step();
    logic [7:0] sw_s;
    logic [7:0] led_s;
    logic [1:0] sel_s;
    logic [1:0] t;
    logic [2:0] tx_s;
    logic       ok;
    sw_s  = i_sw;
    led_s = i_led;
    sel_s = i_uart_sel;
    tx_s  = i_uart_tx;
    @(posedge clk);
    #1;
    edge_cnt++;
    if (tx_s[0] == 1'b0) last_low0 = edge_cnt;
    sw_q.push_back(sw_s);   void'(sw_q.pop_front());
    led_q.push_back(led_s); void'(led_q.pop_front());
    sel_q.push_back(sel_s); void'(sel_q.pop_front());
    tx_q.push_back(tx_s);   void'(tx_q.pop_front());

    // a switch flips once its synchronised level has differed for DB straight samples
    m_rise = 8'h00;
    m_fall = 8'h00;
    for (int b = 0; b < 8; b++) begin
      ok = 1'b1;
      for (int i = 0; i < DB; i++) if (sw_q[HL-3-i][b] == m_db[b]) ok = 1'b0;
      if (ok) begin
        m_rise[b] = ~m_db[b];
        m_fall[b] = m_db[b];
        m_db[b]   = ~m_db[b];
      end
    end

    // mux moves to t after 17 samples requesting t with the last 16 both-high
    m_tx = tx_q[HL-1][m_cur];
    t = sel_q[HL-3];
    if (t != 2'd3 && t != m_cur) begin
      ok = 1'b1;
      for (int j = 0; j <= 16; j++) if (sel_q[HL-3-j] != t) ok = 1'b0;
      for (int j = 0; j < 16; j++) if (!(tx_q[HL-1-j][m_cur] && tx_q[HL-1-j][t])) ok = 1'b0;
      if (ok) m_cur = t;
    end

    check("sw_db", 32'(o_sw_db), 32'(m_db));
    check("sw_rise", 32'(o_sw_rise), 32'(m_rise));
    check("sw_fall", 32'(o_sw_fall), 32'(m_fall));
    if (chk_led) check("led", 32'(o_led), 32'(led_q[HL-2]));
    check("uart_tx", 32'(o_uart_tx), 32'(m_tx));
    check("uart_cur", 32'(o_uart_cur), 32'(m_cur));
  endtask

  initial begin
    rstn       = 1'b0;
    i_sw       = 8'h00;
    i_led      = 8'h00;
    i_led_dim  = 4'hF;
    i_uart_tx  = 3'b111;
    i_uart_sel = 2'd0;
    model_reset();
    #22;
    check("rst_sw_db", 32'(o_sw_db), 32'h0);
    check("rst_sw_rise", 32'(o_sw_rise), 32'h0);
    check("rst_sw_fall", 32'(o_sw_fall), 32'h0);
    check("rst_led", 32'(o_led), 32'h0);
    check("rst_uart_tx", 32'(o_uart_tx), 32'h1);
    check("rst_uart_cur", 32'(o_uart_cur), 32'h0);
    rstn = 1'b1;
    repeat (4) step();

    // 1: single switch accepted after 2+DB clocks
    i_sw = 8'h01;
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (o_sw_db[0] && lat == 0) lat = n;
    end
    check("t1_latency", 32'(lat), 32'd10);
    check("t1_others", 32'(o_sw_db), 32'h01);

    // 2: bouncing shorter than the debounce window is rejected
    for (int c = 0; c < 100; c++) begin
      if (c % 5 == 0) i_sw[3] = ~i_sw[3];
      step();
    end
    check("t2_bounce", 32'(o_sw_db[3]), 32'd0);
    i_sw[3] = 1'b1;
    repeat (9) step();
    check("t2_before", 32'(o_sw_db[3]), 32'd0);
    step();
    check("t2_accept", 32'(o_sw_db[3]), 32'd1);

    // 3: LED latency and dimming
    i_led = 8'hA5;
    step();
    check("t3_led_lat1", 32'(o_led), 32'h00);
    step();
    check("t3_led_lat2", 32'(o_led), 32'hA5);
`ifdef VEERWOLF_LED_PWM_EN
    chk_led = 1'b0;
    i_led_dim = 4'd4;
    repeat (3) step();
    on_cnt = 0; off_cnt = 0;
    repeat (16) begin
      step();
      if (o_led == 8'hA5) on_cnt++;
      else if (o_led == 8'h00) off_cnt++;
    end
    check("t3_pwm4_on", 32'(on_cnt), 32'd4);
    check("t3_pwm4_off", 32'(off_cnt), 32'd12);
    i_led_dim = 4'd0;
    repeat (3) step();
    off_cnt = 0;
    repeat (16) begin
      step();
      if (o_led == 8'h00) off_cnt++;
    end
    check("t3_pwm0_off", 32'(off_cnt), 32'd16);
    i_led_dim = 4'd15;
    repeat (3) step();
    on_cnt = 0;
    repeat (16) begin
      step();
      if (o_led == 8'hA5) on_cnt++;
    end
    check("t3_pwm15_on", 32'(on_cnt), 32'd16);
    chk_led = 1'b1;
`endif

    // 4: switch request mid-frame waits for 16 idle-high clocks
    repeat (3) step();
    frame = {1'b1, 8'h55, 1'b0};
    for (int b = 0; b < 10; b++) begin
      i_uart_tx[0] = frame[b];
      if (b == 3) i_uart_sel = 2'd1;
      repeat (2) step();
      check("t4_hold", 32'(o_uart_cur), 32'd0);
    end
    i_uart_tx[0] = 1'b1;
    sw_edge = 0;
    for (int n = 0; n < 60 && sw_edge == 0; n++) begin
      step();
      if (o_uart_cur == 2'd1) begin
        sw_edge = edge_cnt;
        check("t4_switch_tx", 32'(o_uart_tx), 32'd1);
      end
    end
    check("t4_switched", 32'(sw_edge != 0), 32'd1);
    check("t4_idle_gap", 32'(sw_edge - last_low0), 32'd16);
    step();
    check("t4_after_tx", 32'(o_uart_tx), 32'd1);

    // 5: aborted request and out-of-range select
    i_uart_sel = 2'd0;
    repeat (25) step();
    check("t5_back0", 32'(o_uart_cur), 32'd0);
    i_uart_sel = 2'd1;
    repeat (5) step();
    i_uart_sel = 2'd0;
    repeat (30) step();
    check("t5_abort", 32'(o_uart_cur), 32'd0);
    i_uart_sel = 2'd3;
    repeat (30) step();
    check("t5_out_of_range", 32'(o_uart_cur), 32'd0);

    // 6: asynchronous reset while waiting with cur=1
    i_uart_sel = 2'd1;
    repeat (25) step();
    check("t6_cur1", 32'(o_uart_cur), 32'd1);
    i_uart_sel = 2'd2;
    i_uart_tx  = 3'b101;
    repeat (5) step();
    check("t6_tx_low", 32'(o_uart_tx), 32'd0);
    #3;
    rstn = 1'b0;
    #1;
    check("t6_rst_tx", 32'(o_uart_tx), 32'd1);
    check("t6_rst_cur", 32'(o_uart_cur), 32'd0);
    check("t6_rst_sw_db", 32'(o_sw_db), 32'h0);
    check("t6_rst_led", 32'(o_led), 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3;
    rstn = 1'b1;
    i_uart_tx = 3'b111;
    repeat (25) step();
    check("t6_resume_cur", 32'(o_uart_cur), 32'd2);
    check("t6_resume_sw", 32'(o_sw_db), 32'h09);

    // random phase against the reference model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) i_sw = 8'($urandom);
      i_led = 8'($urandom);
      i_uart_tx = 3'b111 ^ (3'($urandom) & 3'($urandom) & 3'($urandom) & 3'($urandom));
      if ($urandom_range(0, 39) == 0) i_uart_sel = 2'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
